// File: rtl/aes_pkg.sv
// Shared widths and output-stage state encoding for the AES serial loader.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_CNT_W   = 7;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/serial_shift_in.sv
// En-gated LSB-first shift register that presents the word formed by the current edge's shift.
module serial_shift_in #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] word_next
);

  // Only WIDTH-1 bits are stored: the final bit of a block is merged in combinationally on
  // the completing edge, so the oldest bit never has to be held past it.
  logic [WIDTH-2:0] sr_q;
  logic [WIDTH-2:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (en) begin
      sr_d = {bit_in, sr_q[WIDTH-2:1]};
    end
  end

  assign word_next = {bit_in, sr_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/aes_serial_loader.sv
// Bit-serial plaintext/key front end for the AES-128 core with a one-deep valid/ready output stage.
module aes_serial_loader
  import aes_pkg::*;
#(
  parameter int BLOCK_W = AES_BLOCK_W,
  parameter int CNT_W   = AES_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               din,
  input  logic               k_in,
  output logic [BLOCK_W-1:0] data_out,
  output logic [BLOCK_W-1:0] key_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               overflow
);

  out_state_e         state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BLOCK_W-1:0] data_q, data_d;
  logic [BLOCK_W-1:0] key_q, key_d;
  logic               overflow_q, overflow_d;
  logic [BLOCK_W-1:0] data_word;
  logic [BLOCK_W-1:0] key_word;
  logic               complete;
  logic               load;

  serial_shift_in #(.WIDTH(BLOCK_W)) u_data_sr (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .bit_in    (din),
    .word_next (data_word)
  );

  serial_shift_in #(.WIDTH(BLOCK_W)) u_key_sr (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .bit_in    (k_in),
    .word_next (key_word)
  );

  assign complete = en && (bit_cnt_q == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= OUT_EMPTY;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      key_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      key_q      <= key_d;
      overflow_q <= overflow_d;
    end
  end

  // A completion landing on a full, unaccepted stage is dropped and flagged.
  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    load       = 1'b0;
    bit_cnt_d  = en ? bit_cnt_q + CNT_W'(1) : bit_cnt_q;
    case (state_q)
      OUT_EMPTY: begin
        if (complete) begin
          load    = 1'b1;
          state_d = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (complete && out_ready) begin
          load = 1'b1;
        end else if (complete) begin
          overflow_d = 1'b1;
        end else if (out_ready) begin
          state_d = OUT_EMPTY;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
    data_d = load ? data_word : data_q;
    key_d  = load ? key_word  : key_q;
  end

  always_comb begin
    out_valid = (state_q == OUT_FULL);
    busy      = (bit_cnt_q != '0);
    overflow  = overflow_q;
    data_out  = data_q;
    key_out   = key_q;
  end

endmodule

// File: tb/tb_aes_serial_loader.sv
// Directed bench for aes_serial_loader using FIPS-197 and a second hand-picked vector pair.
module tb_aes_serial_loader;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         en = 1'b0;
  logic         din = 1'b0;
  logic         k_in = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] data_out;
  logic [127:0] key_out;
  logic         out_valid;
  logic         busy;
  logic         overflow;

  logic [127:0] d_a;
  logic [127:0] k_a;
  logic [127:0] d_b;
  logic [127:0] k_b;

  int pass_count  = 0;
  int check_count = 0;

  always #5 clk = ~clk;

  aes_serial_loader dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .din       (din),
    .k_in      (k_in),
    .data_out  (data_out),
    .key_out   (key_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overflow  (overflow)
  );

  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    check_count++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end else begin
      pass_count++;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset     = 1'b1;
    en        = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    en = 1'b0;
  endtask

  // Streams bits [first_bit, first_bit+num_bits) of d/k; optionally inserts random en=0 gaps
  // and checks out_valid stays high before each enabled sample.
  task automatic applyStimulus(input logic [127:0] d, input logic [127:0] k,
                               input int first_bit, input int num_bits,
                               input bit gapped, input bit hold_valid);
    for (int i = first_bit; i < first_bit + num_bits; i++) begin
      if (gapped && ($urandom_range(1, 0) == 1)) begin
        @(negedge clk);
        en = 1'b0;
      end
      @(negedge clk);
      if (hold_valid) checkOutput("valid_held", 128'(out_valid), 128'd1);
      en   = 1'b1;
      din  = d[i];
      k_in = k[i];
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    d_a = 128'h3243f6a8885a308d313198a2e0370734;
    k_a = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    d_b = 128'h00112233445566778899aabbccddeeff;
    k_b = 128'h000102030405060708090a0b0c0d0e0f;

    $display("[TB] reset state");
    doReset();
    checkOutput("rst_data", data_out, 128'd0);
    checkOutput("rst_key", key_out, 128'd0);
    checkOutput("rst_valid", 128'(out_valid), 128'd0);
    checkOutput("rst_overflow", 128'(overflow), 128'd0);
    checkOutput("rst_busy", 128'(busy), 128'd0);

    $display("[TB] FIPS-197 vector, continuous enable");
    applyStimulus(d_a, k_a, 0, 127, 1'b0, 1'b0);
    idle();
    checkOutput("fips_valid_early", 128'(out_valid), 128'd0);
    checkOutput("fips_busy_mid", 128'(busy), 128'd1);
    applyStimulus(d_a, k_a, 127, 1, 1'b0, 1'b0);
    idle();
    checkOutput("fips_valid", 128'(out_valid), 128'd1);
    checkOutput("fips_data", data_out, d_a);
    checkOutput("fips_key", key_out, k_a);
    checkOutput("fips_overflow", 128'(overflow), 128'd0);
    checkOutput("fips_busy_done", 128'(busy), 128'd0);

    $display("[TB] gapped enable");
    doReset();
    applyStimulus(d_a, k_a, 0, 1, 1'b1, 1'b0);
    idle();
    checkOutput("gap_busy_first", 128'(busy), 128'd1);
    applyStimulus(d_a, k_a, 1, 126, 1'b1, 1'b0);
    idle();
    checkOutput("gap_valid_early", 128'(out_valid), 128'd0);
    checkOutput("gap_busy_mid", 128'(busy), 128'd1);
    applyStimulus(d_a, k_a, 127, 1, 1'b1, 1'b0);
    idle();
    checkOutput("gap_valid", 128'(out_valid), 128'd1);
    checkOutput("gap_data", data_out, d_a);
    checkOutput("gap_key", key_out, k_a);
    checkOutput("gap_busy_done", 128'(busy), 128'd0);

    $display("[TB] back-to-back with simultaneous accept");
    doReset();
    applyStimulus(d_a, k_a, 0, 128, 1'b0, 1'b0);
    applyStimulus(d_b, k_b, 0, 127, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("b2b_valid_pre", 128'(out_valid), 128'd1);
    checkOutput("b2b_data_pre", data_out, d_a);
    en        = 1'b1;
    din       = d_b[127];
    k_in      = k_b[127];
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    en        = 1'b0;
    checkOutput("b2b_valid_post", 128'(out_valid), 128'd1);
    checkOutput("b2b_data_post", data_out, d_b);
    checkOutput("b2b_key_post", key_out, k_b);
    checkOutput("b2b_overflow", 128'(overflow), 128'd0);

    $display("[TB] overflow");
    doReset();
    applyStimulus(d_a, k_a, 0, 128, 1'b0, 1'b0);
    idle();
    checkOutput("ovf_clear_first", 128'(overflow), 128'd0);
    applyStimulus(d_b, k_b, 0, 128, 1'b0, 1'b0);
    idle();
    checkOutput("ovf_flag", 128'(overflow), 128'd1);
    checkOutput("ovf_data", data_out, d_a);
    checkOutput("ovf_key", key_out, k_a);
    checkOutput("ovf_valid", 128'(out_valid), 128'd1);

    $display("[TB] reset mid-operation");
    doReset();
    applyStimulus(d_b, k_b, 0, 60, 1'b0, 1'b0);
    idle();
    checkOutput("mid_busy", 128'(busy), 128'd1);
    doReset();
    checkOutput("mid_rst_data", data_out, 128'd0);
    checkOutput("mid_rst_key", key_out, 128'd0);
    checkOutput("mid_rst_valid", 128'(out_valid), 128'd0);
    checkOutput("mid_rst_busy", 128'(busy), 128'd0);
    applyStimulus(d_a, k_a, 0, 127, 1'b0, 1'b0);
    idle();
    checkOutput("mid_valid_early", 128'(out_valid), 128'd0);
    applyStimulus(d_a, k_a, 127, 1, 1'b0, 1'b0);
    idle();
    checkOutput("mid_valid", 128'(out_valid), 128'd1);
    checkOutput("mid_data", data_out, d_a);
    checkOutput("mid_key", key_out, k_a);

    $display("[TB] handshake drain");
    doReset();
    applyStimulus(d_b, k_b, 0, 128, 1'b0, 1'b0);
    idle();
    checkOutput("drain_valid", 128'(out_valid), 128'd1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkOutput("drain_data_stable", data_out, d_b);
      checkOutput("drain_key_stable", key_out, k_b);
      checkOutput("drain_valid_hold", 128'(out_valid), 128'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("drain_valid_fall", 128'(out_valid), 128'd0);
    checkOutput("drain_busy", 128'(busy), 128'd0);
    checkOutput("drain_overflow", 128'(overflow), 128'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/aes_serial_loader.md
Name: aes_serial_loader

Overview:
- Bit-serial input front end for the AES-128 cipher core. Deserializes the plaintext stream (din) and key stream (k_in), both LSB first, over 128 enabled cycles.
- Presents the assembled 128-bit plaintext and key to the cipher through a valid/ready handshake.
- Double-buffered: the next block can shift in while the cipher has not yet accepted the previous one.

Parameters:
- BLOCK_W, 128, width of the plaintext and key words; only 128 is supported.
- CNT_W, 7, bit-counter width; must equal log2(BLOCK_W).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  sample enable; din and k_in are taken only on edges where en=1.
- din  input  1  serial plaintext bit, LSB (bit 0) first.
- k_in  input  1  serial key bit, LSB first, aligned with din.
- data_out  output  BLOCK_W  assembled plaintext to the cipher.
- key_out  output  BLOCK_W  assembled key to the cipher.
- out_valid  output  1  data_out/key_out hold an unconsumed block.
- out_ready  input  1  cipher accepts the block.
- busy  output  1  a partial block is in the shift registers (bit_cnt != 0).
- overflow  output  1  sticky; a completed block was dropped because the output stage was still full.

Interface (already decided): one clock; reset is synchronous and active-high.

Behaviour:
- Reset, sampled on a rising clk edge with reset=1:
  - bit_cnt=0; both shift registers = 0.
  - data_out=0, key_out=0, out_valid=0, overflow=0, busy=0.
  - Reset wins over all other inputs on the same edge.
  - Reset mid-stream discards the partial block; no out_valid pulse results from it.
- Input shift, on each edge with en=1 and reset=0:
  - d_sr <= {din, d_sr[127:1]} and k_sr <= {k_in, k_sr[127:1]}.
  - bit_cnt <= bit_cnt+1, wrapping 127 -> 0.
  - After 128 shifts, the first bit received sits at bit 0. The word equals the source vector D, not a bit-reversed copy.
- en=0: shift registers and bit_cnt hold. Gaps of any length inside a block are legal.
- Block completion: an edge with en=1 and bit_cnt=127.
  - The completed word includes the bit sampled on that same edge: {din, d_sr[127:1]}.
  - bit_cnt returns to 0, so streaming can continue back-to-back with no idle cycle.
- Output stage, two states:
  - EMPTY (out_valid=0): block completion loads data_out/key_out and moves to FULL. out_valid is high in the cycle after the completing edge, a latency of 1 edge.
  - FULL (out_valid=1), handshake accepted (out_ready=1) with no completion on the same edge: go to EMPTY. data_out/key_out keep their last value; they are don't-care once invalid.
  - FULL, accept and completion on the same edge: load the new block and stay FULL. out_valid stays high continuously.
  - FULL, completion without accept: overflow <= 1. The new block is dropped; data_out/key_out and out_valid are unchanged.
  - While FULL and out_ready=0: data_out/key_out must be stable.
- overflow is cleared only by reset.
- busy is a combinational decode of bit_cnt != 0.
- No combinational path from out_ready to any output.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_W=128 and AES_CNT_W=7.
  - Output-stage state encoding: OUT_EMPTY=1'b0, OUT_FULL=1'b1.
- One natural sub-module: serial_shift_in.
  - Parameterized width; en-gated right shift with its own counter and a done pulse.
  - Two instances (data, key) share one counter, or the counter lives in the parent and the sub-module is only the shift register. The parent owns the output-stage FSM.

Test Plan:
- FIPS-197 vector:
  - Stimulus: reset 1 cycle. Stream D=3243f6a8885a308d313198a2e0370734 and K=2b7e151628aed2a6abf7158809cf4f3c LSB first with en=1 continuously and out_ready=0.
  - Required: out_valid rises exactly 1 cycle after the 128th enabled edge, data_out=D, key_out=K, overflow=0.
- Gapped enable:
  - Stimulus: same vectors with en toggled randomly (about 50% duty).
  - Required: identical data_out/key_out; out_valid only after exactly 128 enabled samples; busy=1 from the first sample until completion.
- Back-to-back with simultaneous accept:
  - Stimulus: stream block A, then block B (D=00112233445566778899aabbccddeeff, K=000102030405060708090a0b0c0d0e0f) immediately. Hold out_ready=0 until B's completing edge, then pulse out_ready=1 on that edge.
  - Required: out_valid never drops; data_out switches A -> B; overflow=0.
- Overflow:
  - Stimulus: stream two blocks with out_ready=0 throughout.
  - Required: after the second completion overflow=1, data_out/key_out still equal the first block, out_valid=1.
- Reset mid-operation:
  - Stimulus: assert reset after 60 bits of a block, then stream a full fresh vector.
  - Required: outputs are 0 and out_valid=0 after reset; the subsequent block assembles correctly from bit 0, with no residue from the 60 bits.
- Handshake drain:
  - Stimulus: one block, with out_ready held 0 for 20 cycles, then 1.
  - Required: data stable for all 20 cycles; out_valid falls on the edge after acceptance; busy=0.
